// File: rtl/hex_field_parser.sv
// Parses comma/CR/LF-terminated ASCII hex fields into right-aligned values; 2 cycles per accepted digit.
// Result held on oVALID until iREADY; oREADY drops during digit conversion and while a result is pending.
// Optional idle timeout on partial fields via HFP_TIMEOUT_EN.
module hex_field_parser #(
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    iVALID,
    input  logic [7:0]              iDATA,
    output logic                    oREADY,
    output logic                    oVALID,
    output logic [4*MAX_DIGITS-1:0] oFIELD,
    output logic                    oERR,
    input  logic                    iREADY,
    output logic                    oTIMEOUT
);
    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_DIGIT, S_CONV, S_SKIP, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [3:0]      nib_q, nib_d;
    logic            rdy_en_q;

    logic            is_hex, is_term, accept;
    logic [3:0]      nib;

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (iDATA >= 8'h30 && iDATA <= 8'h39) begin
            is_hex = 1'b1;
            nib    = iDATA[3:0];
        end else if ((iDATA >= 8'h41 && iDATA <= 8'h46) || (iDATA >= 8'h61 && iDATA <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = iDATA[3:0] + 4'd9;
        end
        is_term = (iDATA == 8'h0D) || (iDATA == 8'h0A) || (iDATA == 8'h2C);
    end

    // rdy_en_q keeps oREADY low while reset holds the FSM in S_IDLE
    assign oREADY = rdy_en_q && (state_q == S_IDLE || state_q == S_DIGIT || state_q == S_SKIP);
    assign accept = iVALID && oREADY;
    assign oVALID = (state_q == S_OUT);
    assign oERR   = oVALID && err_q;
    assign oFIELD = (oVALID && !err_q) ? acc_q : '0;

`ifdef HFP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
    assign oTIMEOUT = tmo_q;
`else
    assign oTIMEOUT = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        nib_d   = nib_q;
        case (state_q)
            S_IDLE, S_DIGIT: begin
                if (accept) begin
                    if (is_hex) begin
                        if (cnt_q == CW'(MAX_DIGITS)) begin
                            err_d   = 1'b1;
                            state_d = S_SKIP;
                        end else begin
                            nib_d   = nib;
                            state_d = S_CONV;
                        end
                    end else if (is_term) begin
                        if (state_q == S_DIGIT) state_d = S_OUT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end
                end
            end
            S_CONV: begin
                acc_d   = (acc_q << 4) | W'(nib_q);
                cnt_d   = cnt_q + 1'b1;
                state_d = S_DIGIT;
            end
            S_SKIP: begin
                if (accept && is_term) state_d = S_OUT;
            end
            S_OUT: begin
                if (iREADY) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef HFP_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_d     = 1'b0;
        if ((state_q == S_DIGIT || state_q == S_SKIP) && !accept) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                tmo_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            nib_q    <= 4'h0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            nib_q    <= nib_d;
            rdy_en_q <= 1'b1;
        end
    end

`ifdef HFP_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_hex_field_parser.sv
// Directed bench for hex_field_parser; the timeout case adapts to HFP_TIMEOUT_EN.
module tb_hex_field_parser;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        iVALID = 1'b0;
    logic [7:0]  iDATA = 8'h00;
    logic        iREADY = 1'b1;
    logic        oREADY, oVALID, oERR, oTIMEOUT;
    logic [15:0] oFIELD;

    int checks = 0;
    int errors = 0;
    int tmo_seen = 0;
    logic [16:0] res_q[$];

    hex_field_parser #(.MAX_DIGITS(4), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .iVALID(iVALID), .iDATA(iDATA),
        .oREADY(oREADY), .oVALID(oVALID), .oFIELD(oFIELD), .oERR(oERR),
        .iREADY(iREADY), .oTIMEOUT(oTIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Handshakes and timeout pulses are observed mid-cycle, one sample per cycle
    always @(negedge CLK) begin
        if (RST_N && oVALID && iREADY) res_q.push_back({oERR, oFIELD});
        if (oTIMEOUT) tmo_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            iVALID = 1'b1;
            iDATA  = b;
            if (oREADY) begin
                @(posedge CLK);
                #1;
                iVALID = 1'b0;
                done = 1;
            end
        end
        iVALID = 1'b0;
        if (!done) chk("send_stall", 0, 1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic expect_one(input string tag, input logic err, input logic [15:0] field);
        logic [16:0] r;
        for (int i = 0; i < 30 && res_q.size() == 0; i++) @(negedge CLK);
        repeat (10) @(negedge CLK);
        chk({tag, "_count"}, res_q.size(), 1);
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk({tag, "_err"}, r[16], err);
            chk({tag, "_field"}, r[15:0], field);
        end
        res_q.delete();
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ready", oREADY, 0);
        chk("rst_valid", oVALID, 0);
        chk("rst_field", oFIELD, 0);
        chk("rst_err", oERR, 0);
        chk("rst_tmo", oTIMEOUT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_release_ready", oREADY, 1);

        // held result stays stable while downstream stalls
        iREADY = 1'b0;
        send_str("1A3F\r");
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_valid", oVALID, 1);
            chk("hold_field", oFIELD, 16'h1A3F);
            chk("hold_err", oERR, 0);
            chk("hold_ready", oREADY, 0);
        end
        @(posedge CLK);
        #1;
        iREADY = 1'b1;
        expect_one("r1a3f", 0, 16'h1A3F);
        chk("idle_ready", oREADY, 1);

        // lowercase, comma terminator, stray newline discarded
        send_str("ab,\n");
        expect_one("rab", 0, 16'h00AB);

        // illegal character aborts the field, rest absorbed
        send_str("12G4\r");
        expect_one("r12g4", 1, 16'h0000);

        // digit overflow, then a clean field
        send_str("12345\r");
        expect_one("rovf", 1, 16'h0000);
        send_str("7\r");
        expect_one("r7", 0, 16'h0007);

        // partial field left idle
        tmo_seen = 0;
        send_str("12");
        repeat (40) @(negedge CLK);
        chk("tmo_no_valid", res_q.size(), 0);
`ifdef HFP_TIMEOUT_EN
        chk("tmo_pulses", tmo_seen, 1);
        send_str("5\r");
        expect_one("rtmo5", 0, 16'h0005);
`else
        chk("tmo_pulses", tmo_seen, 0);
        send_str("5\r");
        expect_one("rtmo5", 0, 16'h0125);
`endif

        // reset while a result is pending
        iREADY = 1'b0;
        send_str("9\r");
        for (int i = 0; i < 20 && !oVALID; i++) @(negedge CLK);
        chk("pend_valid", oVALID, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", oVALID, 0);
        chk("mid_rst_ready", oREADY, 0);
        chk("mid_rst_field", oFIELD, 0);
        chk("mid_rst_err", oERR, 0);
        chk("mid_rst_tmo", oTIMEOUT, 0);
        @(negedge CLK);
        iREADY = 1'b1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", oREADY, 1);
        repeat (10) @(negedge CLK);
        chk("post_rst_valid", oVALID, 0);
        chk("post_rst_results", res_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule
